// File: rtl/syn_downtimer_4b.sv
// ============================================================================
// Module   : syn_downtimer_4b
// Purpose  : Loadable down-counting timer (IDLE/RUN/HOLD) with one-cycle tc
//            pulse. Define DOWNTIMER_RELOAD_EN for periodic auto-reload.
// Revision : 1.0
// ============================================================================
`default_nettype none

module syn_downtimer_4b #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc
);

  localparam logic [1:0]       c_IDLE = 2'd0;
  localparam logic [1:0]       c_RUN  = 2'd1;
  localparam logic [1:0]       c_HOLD = 2'd2;
  localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             r_busy;
  logic             r_tc;
  logic             w_tc_nxt;
  logic             w_armed;
  logic             w_terminal;
  logic [WIDTH-1:0] w_reload_val;

`ifdef DOWNTIMER_RELOAD_EN
  logic [WIDTH-1:0] r_reload;

  always_ff @(posedge clk) begin
    if (reset)
      r_reload <= '0;
    else if (load)
      r_reload <= din;
  end

  assign w_reload_val = r_reload;
`else
  assign w_reload_val = '0;
`endif

  assign w_armed    = (r_state != c_IDLE);
  // Terminal edge: armed, enabled, last unit left; load pre-empts it.
  assign w_terminal = !load && w_armed && en && (r_count <= c_ONE);

  // State register plus registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_IDLE;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_tc    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_busy  <= (w_state_nxt != c_IDLE);
      r_tc    <= w_tc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (load)
      w_state_nxt = (din != '0) ? c_RUN : c_IDLE;
    else if (w_terminal)
`ifdef DOWNTIMER_RELOAD_EN
      w_state_nxt = c_RUN;
`else
      w_state_nxt = c_IDLE;
`endif
    else if (w_armed)
      w_state_nxt = en ? c_RUN : c_HOLD;
  end

  always_comb begin
    w_count_nxt = r_count;
    w_tc_nxt    = 1'b0;
    if (load) begin
      w_count_nxt = din;
    end else if (w_terminal) begin
      w_count_nxt = w_reload_val;
      w_tc_nxt    = 1'b1;
    end else if (w_armed && en) begin
      w_count_nxt = r_count - c_ONE;
    end
  end

  assign count = r_count;
  assign busy  = r_busy;
  assign tc    = r_tc;

endmodule

`default_nettype wire
